serial_adder: RTL and testbench

Bit-serial ripple adder that accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake. It computes the sum LSB-first, one bit per clock, using a full-adder cell built from two half-adder stages and a registered carry. It returns the WIDTH-bit sum and carry-out over a second valid/ready handshake. It sits directly downstream of the half-adder cell in the arithmetic datapath, trading latency for area in wide, low-rate additions.

---
 rtl/serial_adder.sv | 116 +++++++++++
 tb/tb_serial_adder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial ripple adder. Operands come in over a valid/ready handshake.
// The sum is formed LSB-first, one bit per clock, by a full adder made of
// two half-adder stages and a registered carry. {cout, sum} goes out over a
// second valid/ready handshake. Only one transaction is in flight at a time.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  a_sr_q;
  logic [WIDTH-1:0]  b_sr_q;
  logic [WIDTH-1:0]  psum_q;
  logic [WIDTH-1:0]  sum_q;
  logic [CntW-1:0]   cnt_q;
  logic              c_q;
  logic              cout_q;
  logic              out_valid_q;
  logic              busy_q;

  logic              ha_p;
  logic              ha_g;
  logic              fa_s;
  logic              c_d;
  logic [WIDTH-1:0]  psum_d;
  logic              last_bit;

  // Full-adder cell on the current LSBs, plus the partial-sum shift-in value.
  always_comb begin
    ha_p     = a_sr_q[0] ^ b_sr_q[0];
    ha_g     = a_sr_q[0] & b_sr_q[0];
    fa_s     = ha_p ^ c_q;
    c_d      = ha_g | (ha_p & c_q);
    psum_d   = {fa_s, psum_q[WIDTH-1:1]};
    last_bit = (cnt_q == CntW'(WIDTH - 1));
  end

  // Handshake-facing outputs; in_ready is forced low while reset is held.
  always_comb begin
    in_ready  = (state_q == StIdle) && !rst;
    out_valid = out_valid_q;
    sum       = sum_q;
    cout      = cout_q;
    busy      = busy_q;
  end

  // Control FSM and datapath; reset takes priority over both handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      psum_q      <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      c_q         <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_sr_q  <= a;
            b_sr_q  <= b;
            c_q     <= cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          a_sr_q <= a_sr_q >> 1;
          b_sr_q <= b_sr_q >> 1;
          psum_q <= psum_d;
          c_q    <= c_d;
          cnt_q  <= cnt_q + 1'b1;
          if (last_bit) begin
            // psum_d already holds the final bit in its MSB.
            sum_q       <= psum_d;
            cout_q      <= c_d;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed WIDTH=8 vector table,
// backpressure and mid-run reset sequences, and an exhaustive WIDTH=4 sweep.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;

  logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, busy8;
  logic [7:0] a8, b8, sum8;

  logic       in_valid4, in_ready4, cin4, out_valid4, out_ready4, cout4, busy4;
  logic [3:0] a4, b4, sum4;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .sum       (sum8),
    .cout      (cout8),
    .busy      (busy8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
    .cin       (cin4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .sum       (sum4),
    .cout      (cout4),
    .busy      (busy4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One full WIDTH=8 transaction; result is sampled before the output handshake.
  task automatic run_add8(input logic [7:0] ai, input logic [7:0] bi, input logic ci,
                          output logic [7:0] so, output logic co, output int lat);
    @(negedge clk);
    a8 = ai; b8 = bi; cin8 = ci; in_valid8 = 1'b1;
    check("in_ready_before_accept", in_ready8, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    a8 = ~ai; b8 = 8'h3C; cin8 = ~ci;   // post-accept operand changes must not matter
    check("busy_after_accept", busy8, 1);
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    so = sum8;
    co = cout8;
    out_ready8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready8 = 1'b0;
    check("out_valid_cleared", out_valid8, 0);
    check("busy_cleared", busy8, 0);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [7:0] s;
    logic       c;
    int         lat;
    int         pulses;

    vecs[0] = '{a: 8'h00, b: 8'h00, cin: 1'b0, sum: 8'h00, cout: 1'b0};
    vecs[1] = '{a: 8'h01, b: 8'h00, cin: 1'b1, sum: 8'h02, cout: 1'b0};
    vecs[2] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1};
    vecs[3] = '{a: 8'hA5, b: 8'h5A, cin: 1'b1, sum: 8'h00, cout: 1'b1};
    vecs[4] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sum: 8'h80, cout: 1'b0};
    vecs[5] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1};
    vecs[6] = '{a: 8'h10, b: 8'h20, cin: 1'b0, sum: 8'h30, cout: 1'b0};
    vecs[7] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1};
    vecs[8] = '{a: 8'h3C, b: 8'hC3, cin: 1'b0, sum: 8'hFF, cout: 1'b0};

    rst = 1'b1;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready8, 0);
    check("rst_out_valid", out_valid8, 0);
    check("rst_sum", sum8, 0);
    check("rst_cout", cout8, 0);
    check("rst_busy", busy8, 0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", in_ready8, 1);

    // Directed table
    foreach (vecs[i]) begin
      run_add8(vecs[i].a, vecs[i].b, vecs[i].cin, s, c, lat);
      check($sformatf("vec%0d_sum", i), s, vecs[i].sum);
      check($sformatf("vec%0d_cout", i), c, vecs[i].cout);
      check($sformatf("vec%0d_latency", i), lat, 8);
    end

    // Backpressure: result holds while new operands wait at the input
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h11; cin8 = 1'b0;
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("bp_latency", lat, 8);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d_out_valid", k), out_valid8, 1);
      check($sformatf("bp%0d_sum", k), sum8, 8'h03);
      check($sformatf("bp%0d_cout", k), cout8, 0);
      check($sformatf("bp%0d_in_ready", k), in_ready8, 0);
      @(posedge clk);
      @(negedge clk);
    end
    out_ready8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready8 = 1'b0;
    check("bp_handshake_done", out_valid8, 0);
    check("bp_in_ready_idle", in_ready8, 1);
    check("bp_sum_held_in_idle", sum8, 8'h03);
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    check("bp_held_ops_accepted", busy8, 1);
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("bp2_latency", lat, 8);
    check("bp2_sum", sum8, 8'h66);
    check("bp2_cout", cout8, 0);
    out_ready8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready8 = 1'b0;

    // Reset three cycles into a run: no result for the aborted operation
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; in_valid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    pulses = 0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid8) pulses++;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", out_valid8, 0);
    check("midrst_sum", sum8, 0);
    check("midrst_cout", cout8, 0);
    check("midrst_busy", busy8, 0);
    check("midrst_in_ready", in_ready8, 1);
    repeat (15) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid8) pulses++;
    end
    check("midrst_no_pulse", pulses, 0);
    run_add8(8'h10, 8'h20, 1'b0, s, c, lat);
    check("post_rst_sum", s, 8'h30);
    check("post_rst_cout", c, 0);
    check("post_rst_latency", lat, 8);

    // Exhaustive WIDTH=4 sweep, back-to-back with out_ready held high
    begin
      logic [4:0] expq[$];
      int         timeouts;
      int         nres;
      int         extra;
      logic [4:0] e;
      timeouts = 0;
      nres = 0;
      extra = 0;
      out_ready4 = 1'b1;
      fork
        begin
          for (int i = 0; i < 512; i++) begin
            int guard;
            logic [8:0] v;
            @(negedge clk);
            v = 9'(i);
            a4 = v[3:0]; b4 = v[7:4]; cin4 = v[8]; in_valid4 = 1'b1;
            guard = 0;
            while (!in_ready4 && guard < 20) begin
              @(negedge clk);
              guard++;
            end
            if (guard >= 20) timeouts++;
            @(posedge clk);
            expq.push_back(5'(v[3:0]) + 5'(v[7:4]) + 5'(v[8]));
          end
          @(negedge clk);
          in_valid4 = 1'b0;
        end
        begin
          int cyc;
          cyc = 0;
          while (nres < 512 && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            if (out_valid4) begin
              if (expq.size() == 0) begin
                extra++;
              end else begin
                e = expq.pop_front();
                check($sformatf("ex_a%0h_b%0h", e, nres), {cout4, sum4}, e);
                nres++;
              end
            end
          end
        end
      join
      repeat (10) begin
        @(negedge clk);
        if (out_valid4) extra++;
      end
      check("ex_accept_timeouts", timeouts, 0);
      check("ex_result_count", nres, 512);
      check("ex_extra_results", extra, 0);
      check("ex_queue_empty", expq.size(), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
